// File: rtl/io_channel_bank.sv
// io_channel_bank: I/O channel responder with output registers, input
// synchronizers and an output-event FIFO drained over valid/ready.
module io_channel_bank #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         rst_l,
  input  logic [3:0]   IO_read_sel,
  output logic [14:0]  IO_read_data,
  input  logic [3:0]   IO_write_sel,
  input  logic [14:0]  IO_write_data,
  input  logic         IO_write_en,
  input  logic [119:0] ext_in,
  output logic [119:0] chan_out,
  output logic [7:0]   in_change,
  output logic         ev_valid,
  input  logic         ev_ready,
  output logic [2:0]   ev_chan,
  output logic [14:0]  ev_data,
  output logic         ev_overflow,
  input  logic         ev_ovf_clr
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [14:0]   r_out  [8];
  logic [14:0]   r_sync [8][SYNC_STAGES];
  logic [14:0]   r_hist [8];
  logic [17:0]   r_mem  [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_out_wr;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_out_wr = IO_write_en & ~IO_write_sel[3];
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = ev_valid & ev_ready;
  assign w_push   = w_out_wr & (~w_full | w_pop);
  assign w_drop   = w_out_wr & w_full & ~w_pop;

  // Output channel registers loaded by writeback-stage writes
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 8; i++) r_out[i] <= '0;
    end else if (w_out_wr) begin
      r_out[IO_write_sel[2:0]] <= IO_write_data;
    end
  end

  // Input channel synchronizer chains plus change-detect history
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 8; i++) begin
        for (int s = 0; s < SYNC_STAGES; s++) r_sync[i][s] <= '0;
        r_hist[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_sync[i][0] <= ext_in[15*i +: 15];
        for (int s = 1; s < SYNC_STAGES; s++)
          r_sync[i][s] <= r_sync[i][s-1];
        r_hist[i] <= r_sync[i][SYNC_STAGES-1];
      end
    end
  end

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {IO_write_sel[2:0], IO_write_data};
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow flag; a drop beats a simultaneous clear
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)          r_ovf <= 1'b0;
    else if (w_drop)     r_ovf <= 1'b1;
    else if (ev_ovf_clr) r_ovf <= 1'b0;
  end

  // Combinational channel read with same-cycle write bypass
  always_comb begin
    IO_read_data = '0;
    if (IO_read_sel[3]) begin
      IO_read_data = r_sync[IO_read_sel[2:0]][SYNC_STAGES-1];
    end else if (w_out_wr && IO_write_sel == IO_read_sel) begin
      IO_read_data = IO_write_data;
    end else begin
      IO_read_data = r_out[IO_read_sel[2:0]];
    end
  end

  // Flatten output registers and compute input change pulses
  always_comb begin
    chan_out  = '0;
    in_change = '0;
    for (int i = 0; i < 8; i++) begin
      chan_out[15*i +: 15] = r_out[i];
      in_change[i] = (r_sync[i][SYNC_STAGES-1] != r_hist[i]);
    end
  end

  assign ev_valid    = (r_count != '0);
  assign ev_chan     = r_mem[r_rptr][17:15];
  assign ev_data     = r_mem[r_rptr][14:0];
  assign ev_overflow = r_ovf;

endmodule

// File: tb/tb_io_channel_bank.sv
// tb_io_channel_bank: directed-vector bench for io_channel_bank.
// Inputs change on negedge; outputs are checked away from posedge.
module tb_io_channel_bank;

  localparam int SYNC_STAGES = 2;

  logic         clock;
  logic         rst_l;
  logic [3:0]   IO_read_sel;
  logic [14:0]  IO_read_data;
  logic [3:0]   IO_write_sel;
  logic [14:0]  IO_write_data;
  logic         IO_write_en;
  logic [119:0] ext_in;
  logic [119:0] chan_out;
  logic [7:0]   in_change;
  logic         ev_valid;
  logic         ev_ready;
  logic [2:0]   ev_chan;
  logic [14:0]  ev_data;
  logic         ev_overflow;
  logic         ev_ovf_clr;

  int vectors;
  int miscompares;
  logic [119:0] exp_out;

  io_channel_bank #(.FIFO_DEPTH(4), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock(clock), .rst_l(rst_l),
    .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
    .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
    .IO_write_en(IO_write_en), .ext_in(ext_in),
    .chan_out(chan_out), .in_change(in_change),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_data(ev_data),
    .ev_overflow(ev_overflow), .ev_ovf_clr(ev_ovf_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    IO_read_sel = '0; IO_write_sel = '0; IO_write_data = '0;
    IO_write_en = 1'b0; ext_in = '0; ev_ready = 1'b0; ev_ovf_clr = 1'b0;
    exp_out = '0;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 16; s++) begin
      IO_read_sel = 4'(s);
      #1;
      vectors++;
      if (IO_read_data !== 15'd0) begin
        miscompares++;
        $display("FAIL reset_read sel=%0d got=%o exp=0", s, IO_read_data);
      end
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%b exp=0", ev_valid);
    end
    vectors++;
    if (chan_out !== 120'd0) begin
      miscompares++; $display("FAIL reset_chan_out got=%h exp=0", chan_out);
    end
    vectors++;
    if (ev_overflow !== 1'b0 || in_change !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_flags ovf=%b chg=%h exp=0/00", ev_overflow, in_change);
    end
    @(negedge clock);
    rst_l = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_bypass();
    IO_write_sel = 4'd3; IO_write_data = 15'o12345; IO_write_en = 1'b1;
    IO_read_sel = 4'd3;
    #1;
    vectors++;
    if (IO_read_data !== 15'o12345) begin
      miscompares++;
      $display("FAIL bypass_read got=%o exp=12345", IO_read_data);
    end
    step();
    IO_write_en = 1'b0;
    exp_out[45 +: 15] = 15'o12345;
    #1;
    vectors++;
    if (chan_out !== exp_out) begin
      miscompares++; $display("FAIL wr_chan_out got=%h exp=%h", chan_out, exp_out);
    end
    vectors++;
    if (IO_read_data !== 15'o12345) begin
      miscompares++; $display("FAIL wr_reg_read got=%o exp=12345", IO_read_data);
    end
    vectors++;
    if (ev_valid !== 1'b1 || ev_chan !== 3'd3 || ev_data !== 15'o12345) begin
      miscompares++;
      $display("FAIL wr_event v=%b ch=%0d d=%o exp=1/3/12345",
               ev_valid, ev_chan, ev_data);
    end
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL wr_drain got=%b exp=0", ev_valid);
    end
  endtask

  task automatic test_overflow();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      IO_write_sel = 4'(i); IO_write_data = 15'(i + 1); IO_write_en = 1'b1;
      exp_out[15*i +: 15] = 15'(i + 1);
      step();
    end
    IO_write_en = 1'b0;
    vectors++;
    if (ev_overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_set got=%b exp=1", ev_overflow);
    end
    vectors++;
    if (chan_out !== exp_out) begin
      miscompares++; $display("FAIL ovf_chan_out got=%h exp=%h", chan_out, exp_out);
    end
    repeat (2) step();
    vectors++;
    if (ev_chan !== 3'd0 || ev_data !== 15'd1) begin
      miscompares++;
      $display("FAIL ovf_hold ch=%0d d=%o exp=0/1", ev_chan, ev_data);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ev_valid !== 1'b1 || ev_chan !== 3'(k) || ev_data !== 15'(k + 1)) begin
        miscompares++;
        $display("FAIL ovf_drain%0d v=%b ch=%0d d=%o exp=1/%0d/%o",
                 k, ev_valid, ev_chan, ev_data, k, k + 1);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
    end
    vectors++;
    if (ev_valid !== 1'b0 || ev_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_empty v=%b ovf=%b exp=0/1", ev_valid, ev_overflow);
    end
    ev_ovf_clr = 1'b1;
    step();
    ev_ovf_clr = 1'b0;
    vectors++;
    if (ev_overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clr got=%b exp=0", ev_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IO_write_sel = 4'(i); IO_write_data = 15'(64 + i); IO_write_en = 1'b1;
      exp_out[15*i +: 15] = 15'(64 + i);
      step();
    end
    IO_write_sel = 4'd6; IO_write_data = 15'o666; IO_write_en = 1'b1;
    ev_ready = 1'b1;
    exp_out[90 +: 15] = 15'o666;
    step();
    IO_write_en = 1'b0; ev_ready = 1'b0;
    vectors++;
    if (ev_overflow !== 1'b0) begin
      miscompares++; $display("FAIL fpp_ovf got=%b exp=0", ev_overflow);
    end
    for (int k = 0; k < 4; k++) begin
      logic [2:0]  ec;
      logic [14:0] ed;
      ec = (k == 3) ? 3'd6 : 3'(k + 1);
      ed = (k == 3) ? 15'o666 : 15'(65 + k);
      vectors++;
      if (ev_valid !== 1'b1 || ev_chan !== ec || ev_data !== ed) begin
        miscompares++;
        $display("FAIL fpp_drain%0d v=%b ch=%0d d=%o exp=1/%0d/%o",
                 k, ev_valid, ev_chan, ev_data, ec, ed);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL fpp_empty got=%b exp=0", ev_valid);
    end
  endtask

  task automatic test_input_write_ignored();
    ext_in[15 +: 15] = 15'o1234;
    repeat (SYNC_STAGES + 1) step();
    IO_read_sel = 4'd9;
    IO_write_sel = 4'd9; IO_write_data = 15'o777; IO_write_en = 1'b1;
    #1;
    vectors++;
    if (IO_read_data !== 15'o1234) begin
      miscompares++; $display("FAIL in_nobypass got=%o exp=1234", IO_read_data);
    end
    step();
    IO_write_en = 1'b0;
    #1;
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL in_no_event got=%b exp=0", ev_valid);
    end
    vectors++;
    if (IO_read_data !== 15'o1234 || chan_out !== exp_out) begin
      miscompares++;
      $display("FAIL in_unchanged rd=%o out=%h exp=1234/%h",
               IO_read_data, chan_out, exp_out);
    end
  endtask

  task automatic test_sync_change();
    IO_read_sel = 4'd10;
    ext_in[30 +: 15] = 15'o40000;
    for (int c = 1; c < SYNC_STAGES; c++) begin
      step();
      vectors++;
      if (IO_read_data !== 15'd0 || in_change !== 8'd0) begin
        miscompares++;
        $display("FAIL sync_early%0d rd=%o chg=%h exp=0/00", c, IO_read_data, in_change);
      end
    end
    step();
    vectors++;
    if (IO_read_data !== 15'o40000 || in_change !== 8'h04) begin
      miscompares++;
      $display("FAIL sync_arrive rd=%o chg=%h exp=40000/04", IO_read_data, in_change);
    end
    step();
    vectors++;
    if (IO_read_data !== 15'o40000 || in_change !== 8'd0) begin
      miscompares++;
      $display("FAIL sync_pulse_end rd=%o chg=%h exp=40000/00", IO_read_data, in_change);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      IO_write_sel = 4'(5 + i); IO_write_data = 15'(300 + i); IO_write_en = 1'b1;
      step();
    end
    IO_write_en = 1'b0;
    vectors++;
    if (ev_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_queued got=%b exp=1", ev_valid);
    end
    #2 rst_l = 1'b0;
    #1;
    exp_out = '0;
    vectors++;
    if (ev_valid !== 1'b0 || chan_out !== exp_out || IO_read_data !== 15'd0) begin
      miscompares++;
      $display("FAIL mid_reset v=%b out=%h rd=%o exp=0/0/0",
               ev_valid, chan_out, IO_read_data);
    end
    @(negedge clock);
    rst_l = 1'b1;
    step();
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_after got=%b exp=0", ev_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_bypass();
    test_overflow();
    test_full_push_pop();
    test_input_write_ignored();
    test_sync_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
